// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard and redirect squash sequencer.
// Tracks in-flight RF writes, stalls decode on RAW/WAW/full.
module hazard_scoreboard #(
  parameter int MAX_INFLIGHT = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       id_valid,
  input  logic [5:0] id_rs1,
  input  logic [5:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [5:0] id_rd,
  input  logic       id_rd_we,
  input  logic       wb_valid,
  input  logic [5:0] wb_rd,
  input  logic       update_pc,
  output logic       id_stall,
  output logic       id_issue,
  output logic       id_flush,
  output logic [3:0] inflight_cnt,
  output logic       err_wb_unexpected
);

  localparam logic [3:0] LP_MAX = 4'(MAX_INFLIGHT);
  localparam logic [2:0] LP_FLD = 3'(FLUSH_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_FLUSH
  } state_t;

  state_t      r_state;
  logic [2:0]  r_flush_cnt;
  logic        r_flush;
  logic [63:0] r_pending;
  logic [3:0]  r_cnt;
  logic        r_err;

  logic        w_raw;
  logic        w_waw;
  logic        w_full;
  logic        w_set;
  logic        w_clr;
  logic        w_bad;
  logic [63:0] w_set_mask;
  logic [63:0] w_clr_mask;

  // Hazard detection from registered pending state only
  always_comb begin
    w_raw  = (id_rs1_used & (id_rs1 != 6'd0) & r_pending[id_rs1])
           | (id_rs2_used & (id_rs2 != 6'd0) & r_pending[id_rs2]);
    w_waw  = id_rd_we & (id_rd != 6'd0) & r_pending[id_rd];
    w_full = id_rd_we & (id_rd != 6'd0) & (r_cnt == LP_MAX);
    id_stall = id_valid & ~r_flush & (w_raw | w_waw | w_full);
    id_issue = id_valid & ~r_flush & ~id_stall;
  end

  // Set/clear requests for the pending table
  always_comb begin
    w_set = id_issue & id_rd_we & (id_rd != 6'd0);
    w_clr = wb_valid & (wb_rd != 6'd0) & r_pending[wb_rd];
    w_bad = wb_valid & (wb_rd != 6'd0) & ~r_pending[wb_rd];
    w_set_mask = '0;
    w_clr_mask = '0;
    if (w_set) w_set_mask[id_rd] = 1'b1;
    if (w_clr) w_clr_mask[wb_rd] = 1'b1;
  end

  // Pending bits, in-flight count and sticky error
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_pending <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= (r_pending | w_set_mask) & ~w_clr_mask;
      unique case ({w_set, w_clr})
        2'b10:   r_cnt <= r_cnt + 4'd1;
        2'b01:   r_cnt <= r_cnt - 4'd1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_bad) r_err <= 1'b1;
    end
  end

  // Squash window after a redirect; reload on repeated redirect
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= S_IDLE;
      r_flush_cnt <= '0;
      r_flush     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (update_pc) begin
            r_state     <= S_FLUSH;
            r_flush_cnt <= LP_FLD;
            r_flush     <= 1'b1;
          end
        end
        S_FLUSH: begin
          if (update_pc) begin
            r_flush_cnt <= LP_FLD;
          end else if (r_flush_cnt == 3'd0) begin
            r_state <= S_IDLE;
            r_flush <= 1'b0;
          end else begin
            r_flush_cnt <= r_flush_cnt - 3'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  assign id_flush          = r_flush;
  assign inflight_cnt      = r_cnt;
  assign err_wb_unexpected = r_err;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Register-hazard and control-flush controller for the in-order core. It sits beside decode and tracks which register-file destinations (6-bit address space) have a write still in flight to write-back. It stalls decode on read-after-write (RAW) and write-after-write (WAW) conflicts and on in-flight overflow, and it sequences a fixed-length squash window after every PC redirect.

## Interface
Parameters:
- MAX_INFLIGHT, default 4: maximum outstanding register writes; legal range 1–15.
- FLUSH_CYCLES, default 2: number of cycles decode is squashed after a redirect; legal range 1–7.

Ports:
- i_clk  in  1  core clock; all state updates on the rising edge.
- i_rstn  in  1  reset; asynchronous and active-low.
- id_valid  in  1  decode holds a valid instruction this cycle.
- id_rs1, id_rs2  in  6  source register addresses.
- id_rs1_used, id_rs2_used  in  1  the corresponding source is actually read.
- id_rd  in  6  destination register address.
- id_rd_we  in  1  the instruction writes id_rd.
- wb_valid  in  1  write-back commits a register write this cycle.
- wb_rd  in  6  address being committed.
- update_pc  in  1  PC redirect request from decode.
- id_stall  out  1  combinational: hold the decode and fetch registers.
- id_issue  out  1  combinational: the instruction in decode issues this cycle.
- id_flush  out  1  registered: the decode instruction is squashed (treated as a bubble).
- inflight_cnt  out  4  number of pending register writes.
- err_wb_unexpected  out  1  sticky: a write-back hit a register that was not pending.

## Operation
- State:
  - pending[63:0], one bit per register.
  - inflight_cnt.
  - Flush FSM with states IDLE and FLUSH, plus a 3-bit down-counter flush_cnt.
- Register 0 is never marked pending. A source of 0 never conflicts.
- raw = (id_rs1_used & id_rs1≠0 & pending[id_rs1]) | (id_rs2_used & id_rs2≠0 & pending[id_rs2]).
- waw = id_rd_we & id_rd≠0 & pending[id_rd].
- full = id_rd_we & id_rd≠0 & (inflight_cnt == MAX_INFLIGHT).
- id_stall = id_valid & !id_flush & (raw | waw | full).
- id_issue = id_valid & !id_flush & !id_stall.
- Stall evaluation uses only registered pending state; there is no same-cycle bypass from write-back.
- Issue: if id_issue & id_rd_we & id_rd≠0, then pending[id_rd] is set and inflight_cnt is incremented at the next edge.
- Write-back:
  - If wb_valid & wb_rd≠0 & pending[wb_rd], then pending[wb_rd] is cleared and inflight_cnt is decremented.
  - If wb_valid & wb_rd≠0 & !pending[wb_rd], then err_wb_unexpected is set and no state changes.
- Simultaneous issue and write-back:
  - To different registers: both take effect, and inflight_cnt is unchanged.
  - To the same register: cannot occur, because WAW stalls that issue.
- Flush FSM:
  - IDLE: on update_pc, go to FLUSH and load flush_cnt = FLUSH_CYCLES-1.
  - FLUSH: id_flush=1. If update_pc is asserted, reload flush_cnt = FLUSH_CYCLES-1. Otherwise, if flush_cnt==0, go to IDLE; else decrement flush_cnt.
- Flush does not touch pending bits. Writes already in flight drain normally during FLUSH.
- update_pc together with an issuing instruction in IDLE: that instruction issues, because it is the branch itself. Squashing starts on the next cycle.
- update_pc while id_flush=1 is an illegal upstream request. The FSM still reloads the counter.
- err_wb_unexpected clears only on reset.

## Timing
- Reset values (asynchronous, while i_rstn=0):
  - pending = 0, inflight_cnt = 0, state = IDLE, flush_cnt = 0.
  - id_flush = 0, err_wb_unexpected = 0.
  - id_stall and id_issue are combinational; with no state they are 0 and id_valid respectively.
- Reset asserted mid-operation discards all pending and flush state immediately.
- RAW penalty with write-back committing in cycle N:
  - The stall is visible through cycle N.
  - The dependent instruction issues in N+1 at the earliest.
- Redirect: update_pc at edge N sets id_flush=1 for cycles N+1 … N+FLUSH_CYCLES, and 0 from N+FLUSH_CYCLES+1.
- inflight_cnt and id_flush change only on the rising edge of i_clk.

## Test plan
- Reset then idle: id_valid=1, rs1=5 used, rd=7 we → id_issue=1 and id_stall=0; next cycle pending[7]=1 and inflight_cnt=1.
- RAW: issue rd=7, then decode rs2=7 used. id_stall=1 until wb_valid with wb_rd=7 at cycle N. id_issue=1 at N+1.
- Full: MAX_INFLIGHT=4. Issue writes to rd=1..4. A fifth instruction with rd=9 stalls. A write-back of rd=2 in the same cycle still stalls. The instruction issues the next cycle with inflight_cnt=4.
- Flush: update_pc pulsed at cycle 10 with FLUSH_CYCLES=2 → id_flush=1 in cycles 11–12 and id_issue=0. A second update_pc at cycle 11 extends the flush through cycle 13.
- Register 0 and error: issue rd=0 → inflight_cnt stays 0. wb_valid with wb_rd=12 not pending → err_wb_unexpected=1, sticky until reset.
- Reset mid-flush with three writes pending → all outputs reach their reset values asynchronously. After release, an instruction reading those registers issues without stall.
